// File: rtl/aes_cipher_writeback_if.sv
// Bus bundle for aes_cipher_writeback: CPU store snoop, AES core result
// and the cache_D AES write port. The slave modport is the writeback block.
interface aes_cipher_writeback_if #(
  parameter int BLK_W  = 128,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] cpu_add;
  logic [3:0]        cpu_wen;
  logic              dvld;
  logic [BLK_W-1:0]  cipher;
  logic              wait_en;
  logic              wen_aes_d;
  logic [ADDR_W-1:0] cipher_addr;
  logic [WORD_W-1:0] cipher_text;
  logic              wb_done;
  logic              overrun;

  modport master (
    output cpu_add, cpu_wen, dvld, cipher,
    input  wait_en, wen_aes_d, cipher_addr, cipher_text, wb_done, overrun
  );

  modport slave (
    input  cpu_add, cpu_wen, dvld, cipher,
    output wait_en, wen_aes_d, cipher_addr, cipher_text, wb_done, overrun
  );
endinterface

// File: rtl/aes_cipher_writeback.sv
// aes_cipher_writeback: writes an AES result block into cache_D one word per
// cycle (MSW first), stalling the CPU from a trigger store until writeback end.
// One-deep pending buffer, sticky overrun flag, one-cycle wb_done pulse.
// Optional: define AES_WB_BSWAP_EN to byte-reverse every written word.
module aes_cipher_writeback #(
  parameter int              BLK_W     = 128,
  parameter int              WORD_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4C,
  parameter logic [ADDR_W-1:0] TRIG_ADDR = 32'h30
) (
  input  logic                  clk,
  input  logic                  reset,
  aes_cipher_writeback_if.slave bus
);

  localparam int NWORDS = BLK_W / WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(NWORDS - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WRITE, S_DONE} state_t;

  state_t              r_state, w_state_nx;
  logic [IDX_W-1:0]    r_idx, w_idx_nx;
  logic [BLK_W-1:0]    r_blk, w_blk_nx;
  logic [BLK_W-1:0]    r_pend, w_pend_nx;
  logic                r_pvld, w_pvld_nx;
  logic                r_rearm, w_rearm_nx;
  logic                r_dvld_q;
  logic                r_wait, w_wait_nx;
  logic                r_wen, w_wen_nx;
  logic [ADDR_W-1:0]   r_addr, w_addr_nx;
  logic [WORD_W-1:0]   r_text, w_text_nx;
  logic                r_done, w_done_nx;
  logic                r_overrun, w_ovr_nx;

  logic                w_edge, w_trig, w_start, w_rearm_eff;
  logic [BLK_W-1:0]    w_src;

  function automatic logic [WORD_W-1:0] f_fmt(input logic [WORD_W-1:0] w);
`ifdef AES_WB_BSWAP_EN
    logic [WORD_W-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < WORD_W / 8; b++)
      r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
    return r;
`else
    return w;
`endif
  endfunction

  assign w_edge = bus.dvld & ~r_dvld_q;
  assign w_trig = (bus.cpu_add == TRIG_ADDR) && (bus.cpu_wen != 4'b0000);

  // Next-state, next-output and buffer control; outputs are registered from these.
  // r_blk is a shift register: the word on the bus next is always its top slice.
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_blk_nx    = r_blk;
    w_pend_nx   = r_pend;
    w_pvld_nx   = r_pvld;
    w_rearm_nx  = r_rearm;
    w_wait_nx   = r_wait;
    w_wen_nx    = 1'b0;
    w_addr_nx   = '0;
    w_text_nx   = '0;
    w_done_nx   = 1'b0;
    w_ovr_nx    = r_overrun;
    w_start     = 1'b0;
    w_src       = bus.cipher;
    w_rearm_eff = r_rearm | w_trig;

    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_start = 1'b1;
          if (w_trig) w_wait_nx = 1'b1;
        end else if (w_trig) begin
          w_wait_nx  = 1'b1;
          w_state_nx = S_ARMED;
        end
      end
      S_ARMED: begin
        w_wait_nx = 1'b1;
        if (w_edge) w_start = 1'b1;
      end
      S_WRITE: begin
        if (w_trig) begin
          w_wait_nx  = 1'b1;
          w_rearm_nx = 1'b1;
        end
        if (w_edge) begin
          if (r_pvld) w_ovr_nx = 1'b1;
          else begin
            w_pend_nx = bus.cipher;
            w_pvld_nx = 1'b1;
          end
        end
        if (r_idx == LAST) begin
          w_state_nx = S_DONE;
          w_idx_nx   = '0;
          w_done_nx  = 1'b1;
        end else begin
          w_idx_nx  = r_idx + 1'b1;
          w_wen_nx  = 1'b1;
          w_addr_nx = r_addr + STEP;
          w_text_nx = f_fmt(r_blk[BLK_W-1 -: WORD_W]);
          w_blk_nx  = r_blk << WORD_W;
        end
      end
      S_DONE: begin
        if (w_trig) w_wait_nx = 1'b1;
        if (r_pvld) begin
          w_start    = 1'b1;
          w_src      = r_pend;
          w_pvld_nx  = 1'b0;
          w_rearm_nx = w_rearm_eff;
          if (w_edge) w_ovr_nx = 1'b1;
        end else if (w_edge) begin
          // Latching into the empty buffer and draining it in the same
          // cycle is the same as starting straight from cipher.
          w_start    = 1'b1;
          w_rearm_nx = w_rearm_eff;
        end else if (w_rearm_eff) begin
          w_state_nx = S_ARMED;
          w_wait_nx  = 1'b1;
          w_rearm_nx = 1'b0;
        end else begin
          w_state_nx = S_IDLE;
          w_wait_nx  = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_start) begin
      w_state_nx = S_WRITE;
      w_idx_nx   = '0;
      w_blk_nx   = w_src << WORD_W;
      w_wen_nx   = 1'b1;
      w_addr_nx  = BASE_ADDR;
      w_text_nx  = f_fmt(w_src[BLK_W-1 -: WORD_W]);
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_blk     <= '0;
      r_pend    <= '0;
      r_pvld    <= 1'b0;
      r_rearm   <= 1'b0;
      r_dvld_q  <= 1'b0;
      r_wait    <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_text    <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_blk     <= w_blk_nx;
      r_pend    <= w_pend_nx;
      r_pvld    <= w_pvld_nx;
      r_rearm   <= w_rearm_nx;
      r_dvld_q  <= bus.dvld;
      r_wait    <= w_wait_nx;
      r_wen     <= w_wen_nx;
      r_addr    <= w_addr_nx;
      r_text    <= w_text_nx;
      r_done    <= w_done_nx;
      r_overrun <= w_ovr_nx;
    end
  end

  assign bus.wait_en     = r_wait;
  assign bus.wen_aes_d   = r_wen;
  assign bus.cipher_addr = r_addr;
  assign bus.cipher_text = r_text;
  assign bus.wb_done     = r_done;
  assign bus.overrun     = r_overrun;

endmodule
